// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
// Operator-side front end for the N-bit ALU. Three bouncing active-low push
// buttons are synchronised and debounced into one-cycle press events. Those
// events step a four-stage command FSM that loads operand A, then operand B,
// then lets the operator pick an opcode, and finally captures the ALU result
// and flags for display.
//
// Ports
//   clk, rst                 system clock, asynchronous active-high reset
//   sw[N-1:0]                raw operand switches, sampled on a next event
//   btn_next/btn_up/btn_down raw active-low buttons (asynchronous, bouncing)
//   alu_a, alu_b             registered operands driven to the ALU
//   alu_control[3:0]         registered opcode driven to the ALU
//   alu_result, alu_v/c/n/z  combinational ALU result and flags
//   res_q, flags_q           captured result and flags {v,c,n,z}
//   stage[1:0]               current FSM stage (0 LOAD_A .. 3 SHOW)
//   disp_val[3:0]            nibble for the result 7-seg display
//   done                     one-cycle pulse when a result is captured
module alu_cmd_sequencer #(
   parameter int N               = 4,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int NUM_OPS         = 10
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] sw,
   input  logic         btn_next,
   input  logic         btn_up,
   input  logic         btn_down,
   output logic [N-1:0] alu_a,
   output logic [N-1:0] alu_b,
   output logic [3:0]   alu_control,
   input  logic [N-1:0] alu_result,
   input  logic         alu_v,
   input  logic         alu_c,
   input  logic         alu_n,
   input  logic         alu_z,
   output logic [N-1:0] res_q,
   output logic [3:0]   flags_q,
   output logic [1:0]   stage,
   output logic [3:0]   disp_val,
   output logic         done
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [3:0]    LAST_OP  = 4'(NUM_OPS - 1);

   typedef enum logic [1:0] {
      LOAD_A = 2'd0,
      LOAD_B = 2'd1,
      SEL_OP = 2'd2,
      SHOW   = 2'd3
   } state_t;

   state_t        state;
   logic [2:0]    btn_raw;
   logic [2:0]    sync_1;
   logic [2:0]    sync_2;
   logic [2:0]    accepted;
   logic [2:0]    accepted_d;
   logic [2:0]    press;
   logic [CW-1:0] db_cnt [3];
   logic          ev_next;
   logic          ev_up;
   logic          ev_down;

   assign btn_raw = {btn_next, btn_up, btn_down};
   assign ev_next = press[2];
   assign ev_up   = press[1];
   assign ev_down = press[0];

   // Button conditioning, one lane per button. The raw level goes through a
   // two-flop synchroniser, then a counter that must see the synchronised level
   // disagree with the accepted level for DEBOUNCE_CYCLES consecutive cycles
   // before the accepted level follows it; any agreeing sample restarts the
   // count, so bounces never get through. A press is an accepted 1->0 step,
   // detected against a delayed copy so the pulse lands one edge after the
   // acceptance. Everything idles at "released" (1) out of reset, which is why
   // a button held through reset still produces exactly one press afterwards.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_1     <= '1;
         sync_2     <= '1;
         accepted   <= '1;
         accepted_d <= '1;
         press      <= '0;
         for (int i = 0; i < 3; i++) begin
            db_cnt[i] <= '0;
         end
      end else begin
         sync_1     <= btn_raw;
         sync_2     <= sync_1;
         accepted_d <= accepted;
         press      <= accepted_d & ~accepted;
         for (int i = 0; i < 3; i++) begin
            if (sync_2[i] == accepted[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == CNT_LAST) begin
               accepted[i] <= sync_2[i];
               db_cnt[i]   <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + 1'b1;
            end
         end
      end
   end

   // Command FSM. A next event always wins: it advances the stage and, in
   // SEL_OP, discards any up/down arriving in the same cycle, so the opcode is
   // frozen on the capture cycle and the ALU output being sampled has had at
   // least a full cycle to settle. Up and down together cancel out. Operands
   // and opcode survive the SHOW->LOAD_A wrap so the operator can re-run with
   // small edits.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= LOAD_A;
         alu_a       <= '0;
         alu_b       <= '0;
         alu_control <= '0;
         res_q       <= '0;
         flags_q     <= '0;
         done        <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            LOAD_A: begin
               if (ev_next) begin
                  alu_a <= sw;
                  state <= LOAD_B;
               end
            end
            LOAD_B: begin
               if (ev_next) begin
                  alu_b <= sw;
                  state <= SEL_OP;
               end
            end
            SEL_OP: begin
               if (ev_next) begin
                  res_q   <= alu_result;
                  flags_q <= {alu_v, alu_c, alu_n, alu_z};
                  done    <= 1'b1;
                  state   <= SHOW;
               end else if (ev_up && !ev_down) begin
                  alu_control <= (alu_control == LAST_OP) ? 4'd0 : alu_control + 4'd1;
               end else if (ev_down && !ev_up) begin
                  alu_control <= (alu_control == 4'd0) ? LAST_OP : alu_control - 4'd1;
               end
            end
            SHOW: begin
               if (ev_next) begin
                  state <= LOAD_A;
               end
            end
            default: begin
               state <= LOAD_A;
            end
         endcase
      end
   end

   assign stage = state;

   // Display nibble follows what the operator is currently working on: the
   // live switches while loading operands, the opcode while selecting, and the
   // captured result once shown.
   always_comb begin
      disp_val = sw[3:0];
      case (state)
         SEL_OP:  disp_val = alu_control;
         SHOW:    disp_val = res_q[3:0];
         default: disp_val = sw[3:0];
      endcase
   end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer
// Self-checking bench for alu_cmd_sequencer with a short debounce window.
// A small behavioural ALU drives the result/flag inputs, and an abstract
// operator model (stage number, operands, opcode, captured result) predicts
// every output after each complete button press.
module tb_alu_cmd_sequencer;

   localparam int N    = 4;
   localparam int DC   = 4;
   localparam int NOPS = 10;

   logic         clk;
   logic         rst;
   logic [N-1:0] sw;
   logic         btn_next;
   logic         btn_up;
   logic         btn_down;
   logic [N-1:0] alu_a;
   logic [N-1:0] alu_b;
   logic [3:0]   alu_control;
   logic [N-1:0] alu_result;
   logic         alu_v;
   logic         alu_c;
   logic         alu_n;
   logic         alu_z;
   logic [N-1:0] res_q;
   logic [3:0]   flags_q;
   logic [1:0]   stage;
   logic [3:0]   disp_val;
   logic         done;
   logic [7:0]   alu_out;

   int n_compared;
   int n_mismatched;
   int done_count;

   int         m_stage;
   logic [3:0] m_a;
   logic [3:0] m_b;
   int         m_op;
   logic [3:0] m_res;
   logic [3:0] m_flags;
   int         m_done;

   alu_cmd_sequencer #(
      .N(N),
      .DEBOUNCE_CYCLES(DC),
      .NUM_OPS(NOPS)
   ) dut (
      .clk(clk),
      .rst(rst),
      .sw(sw),
      .btn_next(btn_next),
      .btn_up(btn_up),
      .btn_down(btn_down),
      .alu_a(alu_a),
      .alu_b(alu_b),
      .alu_control(alu_control),
      .alu_result(alu_result),
      .alu_v(alu_v),
      .alu_c(alu_c),
      .alu_n(alu_n),
      .alu_z(alu_z),
      .res_q(res_q),
      .flags_q(flags_q),
      .stage(stage),
      .disp_val(disp_val),
      .done(done)
   );

   // Behavioural 4-bit ALU: returns {v,c,n,z,result}. Op 0 is add, 1 subtract,
   // then logic ops, shifts, increment and decrement.
   function automatic logic [7:0] alu_ref(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
      logic [4:0] w;
      logic [3:0] r;
      logic       v;
      w = '0;
      v = 1'b0;
      case (op)
         4'd0: begin
            w = {1'b0, a} + {1'b0, b};
            v = (a[3] == b[3]) && (w[3] != a[3]);
         end
         4'd1: begin
            w = {1'b0, a} - {1'b0, b};
            v = (a[3] != b[3]) && (w[3] != a[3]);
         end
         4'd2: w = {1'b0, a & b};
         4'd3: w = {1'b0, a | b};
         4'd4: w = {1'b0, a ^ b};
         4'd5: w = {1'b0, ~a};
         4'd6: w = {a, 1'b0};
         4'd7: w = {a[0], 1'b0, a[3:1]};
         4'd8: w = {1'b0, a} + 5'd1;
         4'd9: w = {1'b0, a} - 5'd1;
         default: w = '0;
      endcase
      r = w[3:0];
      return {v, w[4], r[3], (r == 4'd0), r};
   endfunction

   always_comb begin
      alu_out = alu_ref(alu_a, alu_b, alu_control);
   end

   assign alu_result = alu_out[3:0];
   assign alu_z      = alu_out[4];
   assign alu_n      = alu_out[5];
   assign alu_c      = alu_out[6];
   assign alu_v      = alu_out[7];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Count every cycle in which done is seen high, sampled mid-cycle.
   always @(negedge clk) begin
      if (done === 1'b1) done_count++;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "[TB] watchdog");
   end

   task automatic model_reset();
      m_stage = 0;
      m_a     = '0;
      m_b     = '0;
      m_op    = 0;
      m_res   = '0;
      m_flags = '0;
   endtask

   // Operator model: mask = {next, up, down} pressed together.
   task automatic model_apply(input logic [2:0] mask);
      logic [7:0] r;
      if (mask[2]) begin
         case (m_stage)
            0: begin m_a = sw; m_stage = 1; end
            1: begin m_b = sw; m_stage = 2; end
            2: begin
               r = alu_ref(m_a, m_b, 4'(m_op));
               m_res = r[3:0];
               m_flags = r[7:4];
               m_done++;
               m_stage = 3;
            end
            default: m_stage = 0;
         endcase
      end else if (m_stage == 2 && mask[1] != mask[0]) begin
         m_op = mask[1] ? (m_op + 1) % NOPS : (m_op + NOPS - 1) % NOPS;
      end
   endtask

   // Hold the selected buttons low well past the debounce window, then
   // release them long enough for the accepted levels to return to released.
   task automatic press_buttons(input logic [2:0] mask);
      @(negedge clk);
      btn_next = ~mask[2];
      btn_up   = ~mask[1];
      btn_down = ~mask[0];
      repeat (DC + 6) @(negedge clk);
      model_apply(mask);
      btn_next = 1'b1;
      btn_up   = 1'b1;
      btn_down = 1'b1;
      repeat (DC + 6) @(negedge clk);
   endtask

   task automatic test_reset();
      sw = 4'h9;
      btn_next = 1'b1;
      btn_up = 1'b1;
      btn_down = 1'b1;
      rst = 1'b1;
      model_reset();
      m_done = 0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 50; i++) begin
         sw = 4'($urandom);
         @(negedge clk);
      end
      n_compared++;
      if (done_count !== 0) begin n_mismatched++; $display("[TB] FAIL reset_done: got %0d pulses, want 0", done_count); end
      n_compared++;
      if (stage !== 2'd0) begin n_mismatched++; $display("[TB] FAIL reset_stage: got %0d, want 0", stage); end
      n_compared++;
      if ({alu_a, alu_b, alu_control} !== 12'h000) begin n_mismatched++; $display("[TB] FAIL reset_regs: got a=%h b=%h ctl=%h, want 0", alu_a, alu_b, alu_control); end
      n_compared++;
      if ({res_q, flags_q, done} !== 9'h000) begin n_mismatched++; $display("[TB] FAIL reset_capture: got res=%h flags=%b done=%b, want 0", res_q, flags_q, done); end
      sw = 4'hC;
      #1;
      n_compared++;
      if (disp_val !== 4'hC) begin n_mismatched++; $display("[TB] FAIL reset_disp: got %h, want c", disp_val); end
   endtask

   task automatic test_basic_flow();
      sw = 4'h5;
      press_buttons(3'b100);
      sw = 4'h2;
      press_buttons(3'b100);
      press_buttons(3'b100);
      n_compared++;
      if (alu_a !== 4'h5 || alu_b !== 4'h2) begin n_mismatched++; $display("[TB] FAIL flow_operands: got a=%h b=%h, want 5 2", alu_a, alu_b); end
      n_compared++;
      if (res_q !== 4'h7 || flags_q !== 4'b0000) begin n_mismatched++; $display("[TB] FAIL flow_capture: got res=%h flags=%b, want 7 0000", res_q, flags_q); end
      n_compared++;
      if (stage !== 2'd3 || done_count !== 1) begin n_mismatched++; $display("[TB] FAIL flow_stage: got stage=%0d done_pulses=%0d, want 3 1", stage, done_count); end
      n_compared++;
      if (disp_val !== 4'h7) begin n_mismatched++; $display("[TB] FAIL flow_disp: got %h, want 7", disp_val); end
   endtask

   task automatic test_op_select();
      press_buttons(3'b100);
      sw = 4'hA;
      press_buttons(3'b100);
      sw = 4'h6;
      press_buttons(3'b100);
      press_buttons(3'b001);
      n_compared++;
      if (alu_control !== 4'd9) begin n_mismatched++; $display("[TB] FAIL op_wrap_down: got %0d, want 9", alu_control); end
      press_buttons(3'b010);
      n_compared++;
      if (alu_control !== 4'd0) begin n_mismatched++; $display("[TB] FAIL op_wrap_up: got %0d, want 0", alu_control); end
      press_buttons(3'b010);
      press_buttons(3'b011);
      n_compared++;
      if (alu_control !== 4'd1) begin n_mismatched++; $display("[TB] FAIL op_up_down: got %0d, want 1", alu_control); end
      n_compared++;
      if (disp_val !== 4'd1 || stage !== 2'd2) begin n_mismatched++; $display("[TB] FAIL op_disp: got disp=%h stage=%0d, want 1 2", disp_val, stage); end
   endtask

   task automatic test_bounce();
      int base;
      base = done_count;
      for (int r = 0; r < 5; r++) begin
         btn_next = 1'b0;
         repeat (3) @(negedge clk);
         btn_next = 1'b1;
         @(negedge clk);
      end
      btn_next = 1'b0;
      for (int e = 1; e <= 20; e++) begin
         @(negedge clk);
         if (e == DC + 3) begin
            n_compared++;
            if (stage !== 2'd2 || done !== 1'b0) begin n_mismatched++; $display("[TB] FAIL bounce_early: edge %0d got stage=%0d done=%b, want 2 0", e, stage, done); end
         end
         if (e == DC + 4) begin
            n_compared++;
            if (stage !== 2'd3 || done !== 1'b1) begin n_mismatched++; $display("[TB] FAIL bounce_event: edge %0d got stage=%0d done=%b, want 3 1", e, stage, done); end
         end
         if (e == DC + 5) begin
            n_compared++;
            if (done !== 1'b0) begin n_mismatched++; $display("[TB] FAIL bounce_pulse_width: got done=%b, want 0", done); end
         end
      end
      n_compared++;
      if (done_count - base !== 1) begin n_mismatched++; $display("[TB] FAIL bounce_count: got %0d events, want 1", done_count - base); end
      model_apply(3'b100);
      btn_next = 1'b1;
      repeat (DC + 6) @(negedge clk);
      n_compared++;
      if (res_q !== m_res || flags_q !== m_flags) begin n_mismatched++; $display("[TB] FAIL bounce_capture: got res=%h flags=%b, want %h %b", res_q, flags_q, m_res, m_flags); end
   endtask

   task automatic test_flags();
      press_buttons(3'b100);
      sw = 4'h7;
      press_buttons(3'b100);
      sw = 4'h1;
      press_buttons(3'b100);
      press_buttons(3'b001);
      press_buttons(3'b100);
      n_compared++;
      if (res_q !== 4'h8 || flags_q !== 4'b1010) begin n_mismatched++; $display("[TB] FAIL flags_overflow: got res=%h flags=%b, want 8 1010", res_q, flags_q); end
      press_buttons(3'b100);
      n_compared++;
      if (stage !== 2'd0 || alu_a !== 4'h7 || alu_b !== 4'h1 || alu_control !== 4'd0) begin
         n_mismatched++;
         $display("[TB] FAIL show_wrap: got stage=%0d a=%h b=%h ctl=%0d, want 0 7 1 0", stage, alu_a, alu_b, alu_control);
      end
   endtask

   task automatic test_reset_midop();
      sw = 4'h3;
      press_buttons(3'b100);
      press_buttons(3'b100);
      for (int i = 0; i < 6; i++) press_buttons(3'b010);
      n_compared++;
      if (alu_control !== 4'd6 || stage !== 2'd2) begin n_mismatched++; $display("[TB] FAIL midop_setup: got ctl=%0d stage=%0d, want 6 2", alu_control, stage); end
      @(negedge clk);
      btn_up = 1'b0;
      repeat (3) @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      n_compared++;
      if ({alu_a, alu_b, alu_control, res_q, flags_q, stage, done} !== 23'd0) begin
         n_mismatched++;
         $display("[TB] FAIL midop_async_clear: got a=%h b=%h ctl=%h res=%h flags=%b stage=%0d done=%b, want 0", alu_a, alu_b, alu_control, res_q, flags_q, stage, done);
      end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (DC + 12) @(negedge clk);
      n_compared++;
      if (stage !== 2'd0 || alu_control !== 4'd0) begin n_mismatched++; $display("[TB] FAIL midop_held_button: got stage=%0d ctl=%0d, want 0 0", stage, alu_control); end
      btn_up = 1'b1;
      repeat (DC + 6) @(negedge clk);
   endtask

   task automatic test_random();
      logic [2:0]  mask;
      logic [3:0]  exp_disp;
      int          pick;
      for (int it = 0; it < 40; it++) begin
         sw = 4'($urandom);
         pick = int'($urandom_range(0, 10));
         if (pick < 5)       mask = 3'b100;
         else if (pick < 7)  mask = 3'b010;
         else if (pick < 9)  mask = 3'b001;
         else if (pick == 9) mask = 3'b011;
         else                mask = 3'b110;
         press_buttons(mask);
         exp_disp = (m_stage < 2) ? sw : (m_stage == 2) ? 4'(m_op) : m_res;
         n_compared++;
         if (stage !== 2'(m_stage) || alu_a !== m_a || alu_b !== m_b || alu_control !== 4'(m_op)) begin
            n_mismatched++;
            $display("[TB] FAIL rand_state[%0d]: got stage=%0d a=%h b=%h ctl=%0d, want %0d %h %h %0d", it, stage, alu_a, alu_b, alu_control, m_stage, m_a, m_b, m_op);
         end
         n_compared++;
         if (res_q !== m_res || flags_q !== m_flags || done_count !== m_done) begin
            n_mismatched++;
            $display("[TB] FAIL rand_capture[%0d]: got res=%h flags=%b pulses=%0d, want %h %b %0d", it, res_q, flags_q, done_count, m_res, m_flags, m_done);
         end
         n_compared++;
         if (disp_val !== exp_disp) begin n_mismatched++; $display("[TB] FAIL rand_disp[%0d]: got %h, want %h", it, disp_val, exp_disp); end
      end
   endtask

   initial begin
      n_compared   = 0;
      n_mismatched = 0;
      done_count   = 0;
      test_reset();
      test_basic_flow();
      test_op_select();
      test_bounce();
      test_flags();
      test_reset_midop();
      m_done = done_count;
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
